// File: rtl/bnn_stream_controller.sv
// Binary-weight (+/-1) stream sequencer for N parallel lanes between the line buffer and pooling stage.
// PASS mode forwards each weighted beat; ACC mode sums the frame and emits one saturated result per lane.
module bnn_stream_controller #(
    parameter int N  = 6,
    parameter int DW = 16,
    parameter int CW = 10
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            mode,
    input  logic [CW-1:0]   frame_len,
    input  logic [N-1:0]    weight_en,
    input  logic [N-1:0]    weight_bit,
    input  logic [N*DW-1:0] din,
    input  logic            din_valid,
    output logic            din_ready,
    output logic [N*DW-1:0] dout,
    output logic [N-1:0]    ovalid,
    input  logic            dout_ready,
    output logic [N-1:0]    done,
    output logic            busy
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | accepting input beats
    // OUT   | last beat taken, waiting for the output register to drain
    // FIN   | done pulse, back to IDLE next cycle
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT, S_FIN} state_t;

    localparam int AW = DW + CW + 1;

    state_t                r_state, w_next;
    logic                  r_mode;
    logic [CW-1:0]         r_len;
    logic [N-1:0]          r_mask;
    logic [CW-1:0]         r_cnt;
    logic                  r_full;
    logic [N*DW-1:0]       r_dout;
    logic signed [AW-1:0]  r_acc [N];
    logic signed [AW-1:0]  w_wt  [N];
    logic signed [AW-1:0]  w_sum [N];
    logic                  w_drain;
    logic                  w_accept;
    logic                  w_last;

    function automatic logic [DW-1:0] sat(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] hi;
        logic signed [AW-1:0] lo;
        hi = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
        lo = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
        if (v > hi)
            return {1'b0, {(DW-1){1'b1}}};
        else if (v < lo)
            return {1'b1, {(DW-1){1'b0}}};
        else
            return v[DW-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_wt[i]  = {{(AW-DW){din[i*DW+DW-1]}}, din[i*DW +: DW]};
            if (!weight_bit[i])
                w_wt[i] = -w_wt[i];
            w_sum[i] = r_acc[i] + w_wt[i];
        end
    end

    // An all-zero mask never raises ovalid, so the held beat is discarded instead of stalling forever.
    assign w_drain   = r_full && (dout_ready || (r_mask == '0));
    assign din_ready = (r_state == S_RUN) && (r_mode || !r_full || w_drain);
    assign w_accept  = din_valid && din_ready;
    assign w_last    = (r_cnt == r_len - CW'(1));

    assign dout   = r_dout;
    assign ovalid = r_full ? r_mask : '0;
    assign done   = (r_state == S_FIN) ? r_mask : '0;
    assign busy   = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = (frame_len == '0) ? S_FIN : S_RUN;
            end
            S_RUN: begin
                if (w_accept && w_last)
                    w_next = S_OUT;
            end
            S_OUT: begin
                if (!r_full || w_drain)
                    w_next = S_FIN;
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode <= 1'b0;
            r_len  <= '0;
            r_mask <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
            r_dout <= '0;
            for (int i = 0; i < N; i++)
                r_acc[i] <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_mode <= mode;
            r_len  <= frame_len;
            r_mask <= weight_en;
            r_cnt  <= '0;
            r_full <= 1'b0;
            for (int i = 0; i < N; i++)
                r_acc[i] <= '0;
        end else begin
            if (w_accept)
                r_cnt <= r_cnt + CW'(1);
            if (w_accept && r_mode) begin
                for (int i = 0; i < N; i++)
                    if (r_mask[i])
                        r_acc[i] <= w_sum[i];
            end
            // PASS loads every beat; ACC loads only the final sum (including the last beat).
            if (w_accept && (!r_mode || w_last)) begin
                r_full <= 1'b1;
                for (int i = 0; i < N; i++)
                    r_dout[i*DW +: DW] <= !r_mask[i] ? '0 :
                                          (r_mode ? sat(w_sum[i]) : sat(w_wt[i]));
            end else if (w_drain) begin
                r_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bnn_stream_controller.sv
// Randomized self-checking bench for bnn_stream_controller, checked against an integer frame model.
module tb_bnn_stream_controller;
    localparam int N  = 6;
    localparam int DW = 16;
    localparam int CW = 10;

    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic            mode;
    logic [CW-1:0]   frame_len;
    logic [N-1:0]    weight_en;
    logic [N-1:0]    weight_bit;
    logic [N*DW-1:0] din;
    logic            din_valid;
    logic            din_ready;
    logic [N*DW-1:0] dout;
    logic [N-1:0]    ovalid;
    logic            dout_ready;
    logic [N-1:0]    done;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    int            tab_d [32][N];
    logic [N-1:0]  tab_w [32];

    bnn_stream_controller #(.N(N), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode), .frame_len(frame_len),
        .weight_en(weight_en), .weight_bit(weight_bit), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .ovalid(ovalid), .dout_ready(dout_ready),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int rand_val();
        case ($urandom_range(0, 7))
            0:       return -32768;
            1:       return 32767;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    task automatic do_reset();
        rstn = 1'b0; start = 1'b0; mode = 1'b0; frame_len = '0; weight_en = '0;
        weight_bit = '0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    // rdy_mode: 0 always ready, 1 toggle starting high, 2 random. vld_mode: 0 always valid, 1 random.
    task automatic run_frame(input bit m, input int len, input logic [N-1:0] mask, input bit use_tab,
                             input int rdy_mode, input int vld_mode, input int restart_at);
        logic [N*DW-1:0] exp_q [$];
        logic [N*DW-1:0] vec;
        longint          acc [N];
        int              dv [N];
        logic [N-1:0]    wb;
        int              beats, outs, n_out, cyc, budget;
        bit              want_done, finished, exp_rdy;
        for (int i = 0; i < N; i++) acc[i] = 0;
        beats = 0; outs = 0; cyc = 0; finished = 0;
        n_out = (len == 0) ? 0 : (m ? 1 : len);
        want_done = (len == 0);
        budget = 20 + 10 * len;

        @(negedge clk);
        start = 1'b1; mode = m; frame_len = CW'(len); weight_en = mask; din_valid = 1'b0; dout_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!finished) begin
            for (int i = 0; i < N; i++)
                dv[i] = (use_tab && beats < len) ? tab_d[beats][i] : rand_val();
            wb = (use_tab && beats < len) ? tab_w[beats] : N'($urandom);
            for (int i = 0; i < N; i++) din[i*DW +: DW] = dv[i][DW-1:0];
            weight_bit = wb;
            din_valid  = (vld_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            dout_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            start      = (cyc == restart_at);
            if (start) begin
                frame_len = CW'(len + 3);
                mode      = !m;
            end
            #1;
            exp_rdy = (beats < len) && (m || exp_q.size() == 0 || dout_ready);
            chk("busy", busy, 1'b1);
            chk("done", done, want_done ? mask : '0);
            chk("din_ready", din_ready, exp_rdy);
            chk("ovalid", ovalid, (exp_q.size() > 0) ? mask : '0);
            if (exp_q.size() > 0)
                chk("dout", dout, exp_q[0]);
            if (want_done)
                finished = 1;
            if (exp_q.size() > 0 && dout_ready) begin
                void'(exp_q.pop_front());
                outs++;
                if (outs == n_out) want_done = 1;
            end
            if (din_valid && exp_rdy) begin
                beats++;
                vec = '0;
                for (int i = 0; i < N; i++) begin
                    longint w;
                    w = wb[i] ? longint'(dv[i]) : -longint'(dv[i]);
                    if (mask[i]) begin
                        acc[i] += w;
                        vec[i*DW +: DW] = m ? 16'(sat16(acc[i])) : 16'(sat16(w));
                    end
                end
                if (!m || beats == len)
                    exp_q.push_back(vec);
            end
            cyc++;
            if (!finished && cyc > budget) begin
                chk("timeout", 1'b1, 1'b0);
                do_reset();
                return;
            end
            @(negedge clk);
        end
        start = 1'b0; din_valid = 1'b0;
        #1;
        chk("busy_after", busy, 1'b0);
        chk("done_after", done, '0);
    endtask

    initial begin
        do_reset();
        @(negedge clk); #1;
        chk("rst_din_ready", din_ready, 1'b0);
        chk("rst_ovalid", ovalid, '0);
        chk("rst_dout", dout, '0);
        chk("rst_done", done, '0);
        chk("rst_busy", busy, 1'b0);

        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < N; i++) tab_d[b][i] = 100;
            tab_w[b] = (b == 2) ? 6'b000000 : 6'b111111;
        end
        run_frame(1'b1, 4, 6'h3F, 1'b1, 0, 0, -1);

        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < N; i++) tab_d[b][i] = 0;
            tab_d[b][0] = 30000;
            tab_d[b][1] = -30000;
            tab_w[b] = 6'b111111;
        end
        run_frame(1'b1, 3, 6'h3F, 1'b1, 0, 0, -1);

        run_frame(1'b0, 5, 6'b000101, 1'b0, 1, 0, -1);

        for (int i = 0; i < N; i++) tab_d[0][i] = 1000 * i;
        tab_d[0][2] = -32768;
        tab_w[0] = 6'b111011;
        run_frame(1'b0, 1, 6'h3F, 1'b1, 0, 0, -1);

        run_frame(1'b0, 0, 6'b101101, 1'b0, 0, 0, -1);
        run_frame(1'b1, 0, 6'b010010, 1'b0, 0, 0, -1);

        run_frame(1'b0, 6, 6'h3F, 1'b0, 2, 1, 3);
        run_frame(1'b1, 6, 6'h2B, 1'b0, 2, 1, 2);

        @(negedge clk);
        start = 1'b1; mode = 1'b0; frame_len = CW'(4); weight_en = 6'h3F;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) din[i*DW +: DW] = 16'd1234;
        weight_bit = 6'h3F; din_valid = 1'b1; dout_ready = 1'b0;
        @(negedge clk);
        din_valid = 1'b0;
        #1;
        chk("pre_rst_ovalid", ovalid, 6'h3F);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_dout", dout, '0);
        chk("arst_ovalid", ovalid, '0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_din_ready", din_ready, 1'b0);
        chk("arst_done", done, '0);
        @(negedge clk);
        rstn = 1'b1;
        run_frame(1'b1, 5, 6'h3F, 1'b0, 2, 1, -1);

        for (int f = 0; f < 14; f++) begin
            logic [N-1:0] mk;
            mk = N'($urandom_range(1, 63));
            run_frame(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)), mk, 1'b0, 2, 1,
                      ($urandom_range(0, 3) == 0) ? 2 : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end
endmodule
